// File: rtl/mem_arbiter_rr.sv
// N-client arbiter in front of a single cacheline memory port.
// Latches the granted client's command and hands off back-to-back on mem_resp.
module mem_arbiter_rr #(
    parameter int NUM_CLIENTS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int FIXED_PRIORITY = 0,
    localparam int OW            = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            client_read,
    input  logic [NUM_CLIENTS-1:0]            client_write,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
    input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] client_wdata,
    output logic [LINE_WIDTH-1:0]             client_rdata,
    output logic [NUM_CLIENTS-1:0]            client_resp,
    input  logic                              mem_resp,
    input  logic [LINE_WIDTH-1:0]             mem_rdata,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_WIDTH-1:0]             mem_address,
    output logic [LINE_WIDTH-1:0]             mem_wdata,
    output logic [OW-1:0]                     owner,
    output logic                              busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic                    r_read;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_wdata;
    logic [OW-1:0]           r_owner;
    logic                    r_busy;
    logic [OW-1:0]           r_rr_ptr;

    logic [NUM_CLIENTS-1:0]   w_req;
    logic [NUM_CLIENTS-1:0]   w_cand;
    logic [2*NUM_CLIENTS-1:0] w_rot;
    logic [OW-1:0]            w_base;
    logic [OW-1:0]            w_sel;
    logic                     w_found;
    logic                     w_rd;
    logic                     w_wr;
    logic [ADDR_WIDTH-1:0]    w_addr;
    logic [LINE_WIDTH-1:0]    w_wdata;
    logic                     w_load;
    logic                     w_clear;
    logic                     w_resp_en;

    function automatic logic [NUM_CLIENTS-1:0] f_onehot(input logic [OW-1:0] idx);
        return {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Indices may exceed NUM_CLIENTS-1 by less than NUM_CLIENTS; fold them back.
    function automatic logic [OW-1:0] f_wrap(input logic [OW:0] v);
        logic [OW:0] w;
        w = (v >= (OW+1)'(NUM_CLIENTS)) ? (v - (OW+1)'(NUM_CLIENTS)) : v;
        return w[OW-1:0];
    endfunction

    assign w_req     = client_read | client_write;
    assign w_resp_en = (r_state == ST_BUSY) && mem_resp;

    // Owner is masked while busy so a hand-off never regrants the finishing client.
    always_comb begin
        w_cand  = w_req & ((r_state == ST_BUSY) ? ~f_onehot(r_owner) : {NUM_CLIENTS{1'b1}});
        w_base  = (FIXED_PRIORITY != 0) ? {OW{1'b0}} : r_rr_ptr;
        w_rot   = {w_cand, w_cand} >> w_base;
        w_found = |w_rot[NUM_CLIENTS-1:0];
        w_sel   = {OW{1'b0}};
        for (int j = NUM_CLIENTS - 1; j >= 0; j--) begin
            w_sel = w_rot[j] ? f_wrap({1'b0, w_base} + (OW+1)'(j)) : w_sel;
        end
    end

    // Command mux for the selected client.
    always_comb begin
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_addr  = {ADDR_WIDTH{1'b0}};
        w_wdata = {LINE_WIDTH{1'b0}};
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_rd    = (w_sel == OW'(i)) ? client_read[i]  : w_rd;
            w_wr    = (w_sel == OW'(i)) ? client_write[i] : w_wr;
            w_addr  = (w_sel == OW'(i)) ? client_address[i*ADDR_WIDTH +: ADDR_WIDTH] : w_addr;
            w_wdata = (w_sel == OW'(i)) ? client_wdata[i*LINE_WIDTH +: LINE_WIDTH]   : w_wdata;
        end
    end

    // Next-state and load/clear decisions.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nx = ST_BUSY;
                    w_load     = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_resp) begin
                    if (w_found) begin
                        w_state_nx = ST_BUSY;
                        w_load     = 1'b1;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_clear    = 1'b1;
                    end
                end else begin
                    w_state_nx = ST_BUSY;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and latched command registers; a write wins over a simultaneous read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= {ADDR_WIDTH{1'b0}};
            r_wdata  <= {LINE_WIDTH{1'b0}};
            r_owner  <= {OW{1'b0}};
            r_busy   <= 1'b0;
            r_rr_ptr <= {OW{1'b0}};
        end else begin
            r_state <= w_state_nx;
            if (w_load) begin
                r_read   <= w_rd & ~w_wr;
                r_write  <= w_wr;
                r_addr   <= w_addr;
                r_wdata  <= w_wdata;
                r_owner  <= w_sel;
                r_busy   <= 1'b1;
                r_rr_ptr <= f_wrap({1'b0, w_sel} + (OW+1)'(1));
            end else if (w_clear) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                r_addr  <= {ADDR_WIDTH{1'b0}};
                r_wdata <= {LINE_WIDTH{1'b0}};
                r_busy  <= 1'b0;
            end
        end
    end

    assign mem_read     = r_read;
    assign mem_write    = r_write;
    assign mem_address  = r_addr;
    assign mem_wdata    = r_wdata;
    assign owner        = r_owner;
    assign busy         = r_busy;
    assign client_resp  = w_resp_en ? f_onehot(r_owner) : {NUM_CLIENTS{1'b0}};
    assign client_rdata = w_resp_en ? mem_rdata : {LINE_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: one 2-client round-robin instance and
// two 3-client instances (round-robin and fixed priority).
module tb_mem_arbiter_rr;

    logic clk;
    logic rst0;
    logic rst1;
    int   n_tests;
    int   n_fail;

    // 2-client instance
    logic [1:0]   c0_read, c0_write;
    logic [63:0]  c0_addr;
    logic [511:0] c0_wdata;
    logic         m0_resp;
    logic [255:0] m0_rdata;
    logic [255:0] o0_rdata;
    logic [1:0]   o0_resp;
    logic         o0_mrd, o0_mwr, o0_busy;
    logic [31:0]  o0_maddr;
    logic [255:0] o0_mwdata;
    logic [0:0]   o0_owner;

    // 3-client instances (shared address/data inputs)
    logic [2:0]   c1_read, c2_read, c1_write;
    logic [95:0]  c1_addr;
    logic [767:0] c1_wdata;
    logic         m1_resp, m2_resp;
    logic [255:0] m1_rdata;
    logic [255:0] o1_rdata, o2_rdata, o1_mwdata, o2_mwdata;
    logic [2:0]   o1_resp, o2_resp;
    logic         o1_mrd, o1_mwr, o1_busy, o2_mrd, o2_mwr, o2_busy;
    logic [31:0]  o1_maddr, o2_maddr;
    logic [1:0]   o1_owner, o2_owner;

    logic [257:0] q0[$];
    logic [2:0]   q1[$];
    logic [2:0]   q2[$];

    mem_arbiter_rr #(.NUM_CLIENTS(2), .FIXED_PRIORITY(0)) u_dut0 (
        .clk(clk), .rst(rst0), .client_read(c0_read), .client_write(c0_write),
        .client_address(c0_addr), .client_wdata(c0_wdata), .client_rdata(o0_rdata),
        .client_resp(o0_resp), .mem_resp(m0_resp), .mem_rdata(m0_rdata),
        .mem_read(o0_mrd), .mem_write(o0_mwr), .mem_address(o0_maddr),
        .mem_wdata(o0_mwdata), .owner(o0_owner), .busy(o0_busy)
    );

    mem_arbiter_rr #(.NUM_CLIENTS(3), .FIXED_PRIORITY(0)) u_dut1 (
        .clk(clk), .rst(rst1), .client_read(c1_read), .client_write(c1_write),
        .client_address(c1_addr), .client_wdata(c1_wdata), .client_rdata(o1_rdata),
        .client_resp(o1_resp), .mem_resp(m1_resp), .mem_rdata(m1_rdata),
        .mem_read(o1_mrd), .mem_write(o1_mwr), .mem_address(o1_maddr),
        .mem_wdata(o1_mwdata), .owner(o1_owner), .busy(o1_busy)
    );

    mem_arbiter_rr #(.NUM_CLIENTS(3), .FIXED_PRIORITY(1)) u_dut2 (
        .clk(clk), .rst(rst1), .client_read(c2_read), .client_write(c1_write),
        .client_address(c1_addr), .client_wdata(c1_wdata), .client_rdata(o2_rdata),
        .client_resp(o2_resp), .mem_resp(m2_resp), .mem_rdata(m1_rdata),
        .mem_read(o2_mrd), .mem_write(o2_mwr), .mem_address(o2_maddr),
        .mem_wdata(o2_mwdata), .owner(o2_owner), .busy(o2_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected completion whenever a DUT raises client_resp.
    always @(negedge clk) begin
        logic [257:0] e0;
        logic [2:0]   e;
        assert (!(|(c0_read & c0_write))) else $error("client asserted read and write together");
        if (o0_resp !== 2'b00) begin
            n_tests++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL resp0_unexpected: got %b expected none", o0_resp);
            end else begin
                e0 = q0.pop_front();
                if ({o0_resp, o0_rdata} !== e0) begin
                    n_fail++;
                    $display("FAIL resp0: got %b/%h expected %b/%h", o0_resp, o0_rdata, e0[257:256], e0[255:0]);
                end
            end
        end
        if (o1_resp !== 3'b000) begin
            n_tests++;
            e = (q1.size() == 0) ? 3'b000 : q1.pop_front();
            if (o1_resp !== e) begin
                n_fail++;
                $display("FAIL rr3_order: got %b expected %b", o1_resp, e);
            end
        end
        if (o2_resp !== 3'b000) begin
            n_tests++;
            e = (q2.size() == 0) ? 3'b000 : q2.pop_front();
            if (o2_resp !== e) begin
                n_fail++;
                $display("FAIL fp3_order: got %b expected %b", o2_resp, e);
            end
        end
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst0     = 1'b0;
        rst1     = 1'b0;
        c0_read  = 2'b00;
        c0_write = 2'b00;
        c0_addr  = '0;
        c0_wdata = '0;
        m0_resp  = 1'b0;
        m0_rdata = '0;
        c1_read  = 3'b000;
        c2_read  = 3'b000;
        c1_write = 3'b000;
        c1_addr  = {32'h0000_3300, 32'h0000_2200, 32'h0000_1100};
        c1_wdata = '0;
        m1_resp  = 1'b0;
        m2_resp  = 1'b0;
        m1_rdata = {8{32'hC3C3_C3C3}};
        tick();
        tick();

        check("rst_mem_read",  256'(o0_mrd),    256'd0);
        check("rst_mem_write", 256'(o0_mwr),    256'd0);
        check("rst_mem_addr",  256'(o0_maddr),  256'd0);
        check("rst_mem_wdata", o0_mwdata,       256'd0);
        check("rst_busy",      256'(o0_busy),   256'd0);
        check("rst_owner",     256'(o0_owner),  256'd0);
        check("rst_resp",      256'(o0_resp),   256'd0);
        check("rst_rdata",     o0_rdata,        256'd0);
        rst0 = 1'b1;
        rst1 = 1'b1;

        // Single read from client 0
        c0_read  = 2'b01;
        c0_addr  = {32'h0000_0000, 32'h0000_1000};
        tick();
        m0_rdata = {8{32'hAAAA_AAAA}};
        check("t1_mem_read", 256'(o0_mrd),   256'd1);
        check("t1_mem_addr", 256'(o0_maddr), 256'h1000);
        check("t1_busy",     256'(o0_busy),  256'd1);
        check("t1_rdata_gated", o0_rdata,    256'd0);
        m0_resp = 1'b1;
        q0.push_back({2'b01, {8{32'hAAAA_AAAA}}});
        tick();
        m0_resp = 1'b0;
        c0_read = 2'b00;
        check("t1_done_read", 256'(o0_mrd),  256'd0);
        check("t1_done_busy", 256'(o0_busy), 256'd0);
        m0_resp = 1'b1;
        #1;
        check("idle_resp_ignored", 256'(o0_resp), 256'd0);
        m0_resp = 1'b0;

        // Request held through its own response: back to IDLE, then regranted
        c0_read = 2'b01;
        c0_addr = {32'h0000_0000, 32'h0000_5000};
        tick();
        check("t5_owner", 256'(o0_owner), 256'd0);
        m0_resp  = 1'b1;
        m0_rdata = {8{32'h1234_5678}};
        q0.push_back({2'b01, {8{32'h1234_5678}}});
        tick();
        m0_resp = 1'b0;
        check("t5_idle_busy", 256'(o0_busy), 256'd0);
        check("t5_idle_read", 256'(o0_mrd),  256'd0);
        tick();
        check("t5_regrant_busy", 256'(o0_busy), 256'd1);
        check("t5_regrant_read", 256'(o0_mrd),  256'd1);
        m0_resp = 1'b1;
        q0.push_back({2'b01, {8{32'h1234_5678}}});
        tick();
        m0_resp = 1'b0;
        c0_read = 2'b00;

        // Reset mid-transaction between edges
        c0_read = 2'b01;
        c0_addr = {32'h0000_7000, 32'h0000_6000};
        tick();
        check("t6_pre_read", 256'(o0_mrd), 256'd1);
        #2;
        rst0    = 1'b0;
        m0_resp = 1'b1;
        #1;
        check("t6_async_read", 256'(o0_mrd),  256'd0);
        check("t6_async_busy", 256'(o0_busy), 256'd0);
        check("t6_no_resp",    256'(o0_resp), 256'd0);
        m0_resp = 1'b0;
        tick();
        rst0    = 1'b1;
        c0_read = 2'b11;
        tick();
        check("t6_regrant_owner", 256'(o0_owner), 256'd0);
        check("t6_regrant_addr",  256'(o0_maddr), 256'h6000);
        m0_resp  = 1'b1;
        m0_rdata = {8{32'h3333_3333}};
        q0.push_back({2'b01, {8{32'h3333_3333}}});
        tick();
        c0_read = 2'b10;
        m0_resp = 1'b0;
        check("t6_handoff_owner", 256'(o0_owner), 256'd1);
        check("t6_handoff_addr",  256'(o0_maddr), 256'h7000);
        m0_resp  = 1'b1;
        m0_rdata = {8{32'h4444_4444}};
        q0.push_back({2'b10, {8{32'h4444_4444}}});
        tick();
        c0_read = 2'b00;
        m0_resp = 1'b0;
        check("t6_end_busy", 256'(o0_busy), 256'd0);

        // Both request with rr_ptr back at 0: client 0 first, then client 1 with no gap
        c0_read = 2'b11;
        c0_addr = {32'h0000_4000, 32'h0000_3000};
        tick();
        check("t2_first_owner", 256'(o0_owner), 256'd0);
        check("t2_first_addr",  256'(o0_maddr), 256'h3000);
        m0_resp  = 1'b1;
        m0_rdata = {8{32'h1111_1111}};
        q0.push_back({2'b01, {8{32'h1111_1111}}});
        tick();
        c0_read = 2'b10;
        m0_resp = 1'b0;
        check("t2_next_owner", 256'(o0_owner), 256'd1);
        check("t2_next_addr",  256'(o0_maddr), 256'h4000);
        check("t2_next_read",  256'(o0_mrd),   256'd1);
        m0_resp  = 1'b1;
        m0_rdata = {8{32'h2222_2222}};
        q0.push_back({2'b10, {8{32'h2222_2222}}});
        tick();
        c0_read = 2'b00;
        m0_resp = 1'b0;
        check("t2_end_busy", 256'(o0_busy), 256'd0);

        // Write from client 1; inputs changing while busy must not leak through
        c0_write = 2'b10;
        c0_addr  = {32'h0000_2000, 32'h0000_0000};
        c0_wdata = {{8{32'h5555_5555}}, 256'd0};
        tick();
        c0_addr  = {32'h9999_0000, 32'h0000_0000};
        c0_wdata = {{8{32'hFFFF_FFFF}}, 256'd0};
        check("t4_mem_write", 256'(o0_mwr), 256'd1);
        check("t4_mem_read",  256'(o0_mrd), 256'd0);
        tick();
        tick();
        check("t4_hold_addr",  256'(o0_maddr), 256'h2000);
        check("t4_hold_wdata", o0_mwdata,      {8{32'h5555_5555}});
        m0_resp  = 1'b1;
        m0_rdata = 256'd0;
        q0.push_back({2'b10, 256'd0});
        tick();
        c0_write = 2'b00;
        m0_resp  = 1'b0;
        check("t4_end_write", 256'(o0_mwr), 256'd0);

        // 3 clients round-robin, all holding: 0,1,2,0,1,2
        q1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        c1_read = 3'b111;
        tick();
        m1_resp = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) c1_read = 3'b000;
            tick();
        end
        m1_resp = 1'b0;
        check("rr3_end_busy", 256'(o1_busy), 256'd0);

        // 3 clients fixed priority, 0 and 2 holding: 0,2,0,2
        q2 = '{3'b001, 3'b100, 3'b001, 3'b100};
        c2_read = 3'b101;
        tick();
        m2_resp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) c2_read = 3'b000;
            tick();
        end
        m2_resp = 1'b0;
        check("fp3_end_busy", 256'(o2_busy), 256'd0);

        tick();
        check("q0_drained", 256'(q0.size()), 256'd0);
        check("q1_drained", 256'(q1.size()), 256'd0);
        check("q2_drained", 256'(q2.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
Parametrised N-client arbiter between the L1 caches (I-cache, D-cache, future prefetcher/victim buffer) and the single cacheline memory port.
Grants one client at a time. It latches the granted client's command into internal registers and drives memory from them until mem_resp, then hands off to the next client.
Supports round-robin or fixed-priority selection. It never regrants a client on the same cycle that client receives its response.

Parameters:
NUM_CLIENTS, 2, number of requesting clients (2..8); client 0 is the I-cache, client 1 is the D-cache.
ADDR_WIDTH, 32, memory address width.
LINE_WIDTH, 256, cacheline data width.
FIXED_PRIORITY, 0, 0 = round-robin; 1 = fixed priority, lowest index highest.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
client_read  input  NUM_CLIENTS  per-client read request, bit i = client i
client_write  input  NUM_CLIENTS  per-client write request
client_address  input  NUM_CLIENTS*ADDR_WIDTH  packed addresses, client i at slice i
client_wdata  input  NUM_CLIENTS*LINE_WIDTH  packed write lines
client_rdata  output  LINE_WIDTH  read line, shared by all clients
client_resp  output  NUM_CLIENTS  one-hot completion pulse
mem_resp  input  1  memory completion, one cycle
mem_rdata  input  LINE_WIDTH  memory read line
mem_read  output  1  memory read command
mem_write  output  1  memory write command
mem_address  output  ADDR_WIDTH  memory address
mem_wdata  output  LINE_WIDTH  memory write line
owner  output  $clog2(NUM_CLIENTS) (min 1)  index of the current or last granted client
busy  output  1  1 while a transaction is outstanding

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, busy=0, owner=0.
  - client_resp=0, client_rdata=0.
  - rr_ptr=0.
  - Memory commands drop immediately, with no clock edge needed. Reset mid-transaction abandons it and issues no client_resp.
- Request: req[i] = client_read[i] | client_write[i]. A client holds its request until its client_resp.
- States: IDLE and BUSY.
  - IDLE: if any req is set, the selected client's read/write/address/wdata are latched on the clock edge. owner and busy are registered on the same edge. Next state is BUSY. mem_read/mem_write assert the cycle after the request is first seen (1-cycle grant latency).
  - BUSY: memory outputs come only from the latched registers, so client inputs are ignored while busy. A client changing its inputs mid-transaction has no effect.
  - BUSY with mem_resp=1: client_resp[owner]=1 combinationally in that cycle and client_rdata=mem_rdata. On the same edge the arbiter re-arbitrates among requesters with the owner masked out.
    - If a requester exists: latch it and stay BUSY. The back-to-back hand-off has no idle cycle.
    - If none: go to IDLE and clear the command registers (mem_read=mem_write=0).
- client_rdata=0 and all client_resp=0 whenever mem_resp=0 or state=IDLE. A mem_resp in IDLE is ignored.
- Round-robin selection: search from index rr_ptr upward with wrap-around and take the first requester. On each grant, rr_ptr <= granted+1 mod NUM_CLIENTS.
- Fixed-priority selection: the lowest-index requester, owner masked during hand-off. rr_ptr is unused.
- Read and write asserted together by one client is illegal. The write wins and the read is dropped; the bench flags it with an assertion.
- Starvation bound: in round-robin mode, a holding requester is granted within NUM_CLIENTS-1 transactions.
- Arithmetic: all index math is modulo NUM_CLIENTS. NUM_CLIENTS need not be a power of 2.

Test Plan:
- Reset, then client_read=2'b01, addr0=0x0000_1000 -> mem_read=1, mem_address=0x1000 next cycle; mem_resp with mem_rdata=0xAA..AA -> client_resp=2'b01, client_rdata=0xAA..AA; next cycle mem_read=0, busy=0.
- Both clients request from IDLE (rr_ptr=0) -> client 0 is served first. At its mem_resp, client 1 is latched, and mem_address equals addr1 on the very next cycle.
- NUM_CLIENTS=3 round-robin, all three requesting continuously -> grant order 0,1,2,0,1,2. With FIXED_PRIORITY=1 and 0 and 2 holding -> order 0,2,0,2, because owner masking alternates them.
- Client 1 write (addr 0x2000, wdata 0x55..55), then it changes addr/wdata while BUSY -> mem_address stays 0x2000 and mem_wdata stays 0x55..55 until mem_resp.
- Client 0's request is still high during the cycle of its own resp, with no other requester -> state returns to IDLE (not regranted), then client 0 is granted one cycle later.
- rst driven low mid-transaction, between clock edges -> mem_read/mem_write drop in the same cycle; no client_resp; after release, the pending request is granted from IDLE with rr_ptr=0.
